// File: rtl/ibus_fetcher.sv
// Instruction fetcher: walks the PC over a request/response instruction bus and hands
// (instr, pc) pairs to decode. Optional perf counters with `define IFETCH_PERF_EN.
module ibus_fetcher #(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    output logic [2:0]  ireq_size,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_wait
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state, state_d;
    logic [63:0] pc, pc_d;
    logic        kill_pending, kill_pending_d;
    logic [63:0] kill_pc, kill_pc_d;
    logic [31:0] instr_q, instr_q_d;
    logic [63:0] pc_plus4;
    logic [63:0] kill_target;

    assign pc_plus4    = pc + 64'd4;
    assign kill_target = redirect_valid ? redirect_pc : kill_pc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            pc           <= PC_RESET;
            kill_pending <= 1'b0;
            kill_pc      <= '0;
            instr_q      <= '0;
        end else begin
            state        <= state_d;
            pc           <= pc_d;
            kill_pending <= kill_pending_d;
            kill_pc      <= kill_pc_d;
            instr_q      <= instr_q_d;
        end
    end

    // Misaligned targets skip the bus entirely and go straight to HOLD.
    always_comb begin
        state_d        = state;
        pc_d           = pc;
        kill_pending_d = kill_pending;
        kill_pc_d      = kill_pc;
        instr_q_d      = instr_q;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = (|redirect_pc[1:0]) ? HOLD : ADDR;
                end else begin
                    state_d = (|pc[1:0]) ? HOLD : ADDR;
                end
            end
            ADDR: begin
                if (iresp_addr_ok) begin
                    state_d = DATA;
                    if (redirect_valid) begin
                        kill_pending_d = 1'b1;
                        kill_pc_d      = redirect_pc;
                    end
                end else if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = (|redirect_pc[1:0]) ? HOLD : ADDR;
                end
            end
            DATA: begin
                if (iresp_data_ok) begin
                    if (kill_pending || redirect_valid) begin
                        kill_pending_d = 1'b0;
                        pc_d           = kill_target;
                        state_d        = (|kill_target[1:0]) ? HOLD : ADDR;
                    end else begin
                        instr_q_d = iresp_data;
                        state_d   = HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_pending_d = 1'b1;
                    kill_pc_d      = redirect_pc;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = (|redirect_pc[1:0]) ? HOLD : ADDR;
                end else if (out_ready) begin
                    pc_d    = pc_plus4;
                    state_d = (|pc_plus4[1:0]) ? HOLD : ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ireq_valid = (state == ADDR);
    assign ireq_addr  = pc;
    assign ireq_size  = 3'b010;
    assign out_valid  = (state == HOLD);
    assign out_instr  = (state == HOLD && pc[1:0] == 2'b00) ? instr_q : 32'h0;
    assign out_pc     = pc;

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_fetched <= '0;
            perf_wait    <= '0;
        end else begin
            if (state == HOLD && out_ready)
                perf_fetched <= perf_fetched + 64'd1;
            if ((state == ADDR && !iresp_addr_ok) || (state == DATA && !iresp_data_ok))
                perf_wait <= perf_wait + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ibus_fetcher.sv
// Directed bench for ibus_fetcher: inputs change 2 time units after each rising edge,
// outputs are checked at that same point, away from the active edge.
module tb_ibus_fetcher;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic [2:0]  ireq_size;
    logic        iresp_addr_ok = 1'b0;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;

    int total = 0;
    int bad = 0;

    ibus_fetcher dut (
        .clk(clk),
        .resetn(resetn),
        .ireq_valid(ireq_valid),
        .ireq_addr(ireq_addr),
        .ireq_size(ireq_size),
        .iresp_addr_ok(iresp_addr_ok),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data(iresp_data),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_ready(out_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic aok, input logic dok, input logic [31:0] data,
                                 input logic ready, input logic rv, input logic [63:0] rpc);
        iresp_addr_ok  = aok;
        iresp_data_ok  = dok;
        iresp_data     = data;
        out_ready      = ready;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Shorthand for the usual trio of output checks in one state.
    task automatic checkFetch(input string tag, input logic req, input logic val,
                              input logic [63:0] pc, input logic [31:0] instr);
        checkOutput({tag, "_ireq_valid"}, {63'd0, ireq_valid}, {63'd0, req});
        checkOutput({tag, "_out_valid"}, {63'd0, out_valid}, {63'd0, val});
        if (req) checkOutput({tag, "_ireq_addr"}, ireq_addr, pc);
        if (val) begin
            checkOutput({tag, "_out_pc"}, out_pc, pc);
            checkOutput({tag, "_out_instr"}, {32'd0, out_instr}, {32'd0, instr});
        end
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        tick(2);
        checkOutput("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_out_instr", {32'd0, out_instr}, 64'd0);
        checkOutput("rst_out_pc", out_pc, 64'h8000_0000);
        checkOutput("rst_ireq_size", {61'd0, ireq_size}, 64'd2);

        // Zero-wait streaming, one instruction per three cycles
        resetn = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 64'h0);
        tick(1); checkFetch("s0_addr", 1'b1, 1'b0, 64'h8000_0000, 32'h0);
        tick(1); checkFetch("s0_data", 1'b0, 1'b0, 64'h8000_0000, 32'h0);
        tick(1); checkFetch("s0_hold", 1'b0, 1'b1, 64'h8000_0000, 32'h0000_0013);
        tick(1); checkFetch("s1_addr", 1'b1, 1'b0, 64'h8000_0004, 32'h0);
        tick(1); checkFetch("s1_data", 1'b0, 1'b0, 64'h8000_0004, 32'h0);
        tick(1); checkFetch("s1_hold", 1'b0, 1'b1, 64'h8000_0004, 32'h0000_0013);

        // Downstream stall for 5 cycles in HOLD
        applyStimulus(1'b1, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            tick(1); checkFetch("stall_hold", 1'b0, 1'b1, 64'h8000_0004, 32'h0000_0013);
        end

        // Release; address accept delayed 4 cycles
        applyStimulus(1'b0, 1'b0, 32'h0000_0013, 1'b1, 1'b0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick(1); checkFetch("wait_addr", 1'b1, 1'b0, 64'h8000_0008, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b0, 64'h0);
        tick(1); checkFetch("wait_data", 1'b0, 1'b0, 64'h8000_0008, 32'h0);

        // Redirect in DATA: stale word must be dropped
        applyStimulus(1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b1, 64'h8000_1000);
        tick(1); checkFetch("kill_data", 1'b0, 1'b0, 64'h8000_0008, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 64'h0);
        tick(1); checkFetch("kill_addr", 1'b1, 1'b0, 64'h8000_1000, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0093, 1'b0, 1'b0, 64'h0);
        tick(2); checkFetch("kill_hold", 1'b0, 1'b1, 64'h8000_1000, 32'h0000_0093);

        // Misaligned redirect from HOLD: no bus request, zero instruction
        applyStimulus(1'b1, 1'b1, 32'h0000_0093, 1'b0, 1'b1, 64'h8000_0002);
        tick(1); checkFetch("mis_hold", 1'b0, 1'b1, 64'h8000_0002, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0093, 1'b0, 1'b0, 64'h0);
        tick(2); checkFetch("mis_stay", 1'b0, 1'b1, 64'h8000_0002, 32'h0);

        // Redirect coincident with address accept
        applyStimulus(1'b1, 1'b1, 32'h0000_0093, 1'b1, 1'b1, 64'h8000_0100);
        tick(1); checkFetch("co_addr", 1'b1, 1'b0, 64'h8000_0100, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0093, 1'b1, 1'b1, 64'h8000_0200);
        tick(1); checkFetch("co_data", 1'b0, 1'b0, 64'h8000_0100, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0BAD, 1'b1, 1'b0, 64'h0);
        tick(1); checkFetch("co_addr2", 1'b1, 1'b0, 64'h8000_0200, 32'h0);

        // Redirect and data_ok in the same DATA cycle
        tick(1); checkFetch("same_data", 1'b0, 1'b0, 64'h8000_0200, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0BAD, 1'b1, 1'b1, 64'h8000_0300);
        tick(1); checkFetch("same_addr", 1'b1, 1'b0, 64'h8000_0300, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b0, 64'h0);
        tick(1); checkFetch("rst_pre", 1'b0, 1'b0, 64'h8000_0300, 32'h0);

        // Asynchronous reset while in DATA
        resetn = 1'b0;
        #1;
        checkOutput("arst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        checkOutput("arst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("arst_out_instr", {32'd0, out_instr}, 64'd0);
        checkOutput("arst_out_pc", out_pc, 64'h8000_0000);
        tick(1);
        resetn = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 64'h0);
        tick(1); checkFetch("rr_addr", 1'b1, 1'b0, 64'h8000_0000, 32'h0);
        tick(1); checkFetch("rr_stale", 1'b1, 1'b0, 64'h8000_0000, 32'h0);

        // Redirect in ADDR before the handshake retargets the request
        applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b1, 64'h8000_0040);
        tick(1); checkFetch("ra_addr", 1'b1, 1'b0, 64'h8000_0040, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 64'h0);
        tick(1); checkFetch("ra_data", 1'b0, 1'b0, 64'h8000_0040, 32'h0);
        tick(1); checkFetch("ra_hold", 1'b0, 1'b1, 64'h8000_0040, 32'h0000_0013);
        tick(1); checkFetch("ra_next", 1'b1, 1'b0, 64'h8000_0044, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
